// File: rtl/pipe_pkg.sv
// Shared types and widths for the valid/ready pipeline stage buffer.
package pipe_pkg;

    localparam int unsigned PERF_CNT_W = 32;
    localparam int unsigned SKID_ST_W  = 2;

    typedef enum logic [SKID_ST_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control FSM for the 2-entry skid mode: tracks occupancy, registers upstream
// ready and downstream valid, and steers loads of the main and skid payloads.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic pre_valid_i,
    input  logic post_ready_i,
    output logic pre_ready_o,
    output logic post_valid_o,
    output logic main_load_c_o,
    output logic main_from_skid_c_o,
    output logic skid_load_c_o
);

    logic [SKID_ST_W-1:0] state_raw_q;
    skid_state_e          state_q;
    skid_state_e          state_d;
    logic                 in_fire;
    logic                 out_fire;

    assign state_q  = skid_state_e'(state_raw_q);
    assign in_fire  = pre_valid_i & pre_ready_o;
    assign out_fire = post_valid_o & post_ready_i;

    stl_reg #(.WIDTH(SKID_ST_W), .RST_VAL(SKID_ST_W'(ST_EMPTY))) u_state (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(state_d), .q_o(state_raw_q)
    );

    // Ready and valid are decoded from the next state so both leave on flops.
    stl_reg #(.WIDTH(1), .RST_VAL(1'b1)) u_ready (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(state_d != ST_TWO), .q_o(pre_ready_o)
    );

    stl_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(state_d != ST_EMPTY), .q_o(post_valid_o)
    );

    always_comb begin
        state_d            = state_q;
        main_load_c_o      = 1'b0;
        main_from_skid_c_o = 1'b0;
        skid_load_c_o      = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d       = ST_ONE;
                        main_load_c_o = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load_c_o = 1'b1;
                    end else if (in_fire) begin
                        state_d       = ST_TWO;
                        skid_load_c_o = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d            = ST_ONE;
                        main_load_c_o      = 1'b1;
                        main_from_skid_c_o = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/stl_reg.sv
// Generic enabled flop bank with synchronous active-high reset.
module stl_reg #(
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised valid/ready pipeline stage register with optional skid buffer,
// flush and nop substitution. Perf counters enabled by PIPE_PERF_CNT_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 64,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned      SKID    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_nop,
    input  logic                  i_pre_valid,
    output logic                  o_pre_ready,
    input  logic [WIDTH-1:0]      i_pre_data,
    output logic                  o_post_valid,
    input  logic                  i_post_ready,
    output logic [WIDTH-1:0]      o_post_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] o_perf_stall,
    output logic [PERF_CNT_W-1:0] o_perf_flush
`endif
);

    logic [WIDTH-1:0] cap_data;

    assign cap_data = i_nop ? NOP_VAL : i_pre_data;

    if (SKID != 0) begin : g_skid
        logic             main_load;
        logic             main_from_skid;
        logic             skid_load;
        logic [WIDTH-1:0] skid_q;
        logic [WIDTH-1:0] main_d;

        pipe_skid_ctrl u_ctrl (
            .clk_i              (i_clk),
            .rst_i              (i_rst),
            .flush_i            (i_flush),
            .pre_valid_i        (i_pre_valid),
            .post_ready_i       (i_post_ready),
            .pre_ready_o        (o_pre_ready),
            .post_valid_o       (o_post_valid),
            .main_load_c_o      (main_load),
            .main_from_skid_c_o (main_from_skid),
            .skid_load_c_o      (skid_load)
        );

        assign main_d = main_from_skid ? skid_q : cap_data;

        stl_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
            .clk_i(i_clk), .rst_i(i_rst), .en_i(main_load), .d_i(main_d), .q_o(o_post_data)
        );

        stl_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
            .clk_i(i_clk), .rst_i(i_rst), .en_i(skid_load), .d_i(cap_data), .q_o(skid_q)
        );
    end else begin : g_plain
        logic in_fire;
        logic out_fire;
        logic valid_d;

        assign o_pre_ready = !o_post_valid | i_post_ready;
        assign in_fire     = i_pre_valid & o_pre_ready;
        assign out_fire    = o_post_valid & i_post_ready;

        // A capture accepted during flush is dropped, so it never loads main.
        always_comb begin
            valid_d = o_post_valid;
            if (i_flush) begin
                valid_d = 1'b0;
            end else if (in_fire) begin
                valid_d = 1'b1;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end

        stl_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
            .clk_i(i_clk), .rst_i(i_rst), .en_i(1'b1), .d_i(valid_d), .q_o(o_post_valid)
        );

        stl_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
            .clk_i(i_clk), .rst_i(i_rst), .en_i(in_fire & !i_flush), .d_i(cap_data),
            .q_o(o_post_data)
        );
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;

    // Saturating counters; only reset clears them.
    stl_reg #(.WIDTH(PERF_CNT_W), .RST_VAL('0)) u_perf_stall (
        .clk_i(i_clk), .rst_i(i_rst),
        .en_i (o_post_valid & !i_post_ready & (o_perf_stall != CNT_MAX)),
        .d_i  (o_perf_stall + PERF_CNT_W'(1)),
        .q_o  (o_perf_stall)
    );

    stl_reg #(.WIDTH(PERF_CNT_W), .RST_VAL('0)) u_perf_flush (
        .clk_i(i_clk), .rst_i(i_rst),
        .en_i (i_flush & (o_perf_flush != CNT_MAX)),
        .d_i  (o_perf_flush + PERF_CNT_W'(1)),
        .q_o  (o_perf_flush)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=0 and SKID=1 instances share stimulus and are
// checked every cycle against a queue model, plus directed literal checks.
module tb_pipe_stage_buf;

    localparam logic [7:0] NOP  = 8'h13;
    localparam logic [7:0] RSTV = 8'hE5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       nop = 1'b0;
    logic       pre_valid = 1'b0;
    logic       post_ready = 1'b0;
    logic [7:0] pre_data = 8'h00;

    logic       rdy0, rdy1, pv0, pv1;
    logic [7:0] pd0, pd1;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] st0, st1, fl0, fl1;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: each stage is an in-order queue of bounded depth; the output data
    // is whatever entry last sat at the head.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0 = RSTV;
    logic [7:0] last1 = RSTV;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(8), .NOP_VAL(NOP), .RST_VAL(RSTV), .SKID(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_nop(nop),
        .i_pre_valid(pre_valid), .o_pre_ready(rdy0), .i_pre_data(pre_data),
        .o_post_valid(pv0), .i_post_ready(post_ready), .o_post_data(pd0)
`ifdef PIPE_PERF_CNT_EN
        , .o_perf_stall(st0), .o_perf_flush(fl0)
`endif
    );

    pipe_stage_buf #(.WIDTH(8), .NOP_VAL(NOP), .RST_VAL(RSTV), .SKID(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_nop(nop),
        .i_pre_valid(pre_valid), .o_pre_ready(rdy1), .i_pre_data(pre_data),
        .o_post_valid(pv1), .i_post_ready(post_ready), .o_post_data(pd1)
`ifdef PIPE_PERF_CNT_EN
        , .o_perf_stall(st1), .o_perf_flush(fl1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit in0, out0, in1, out1;
        if (rst) begin
            q0.delete();
            q1.delete();
            last0 = RSTV;
            last1 = RSTV;
        end else begin
            out0 = (q0.size() != 0) && post_ready;
            in0  = pre_valid && ((q0.size() == 0) || post_ready);
            out1 = (q1.size() != 0) && post_ready;
            in1  = pre_valid && (q1.size() < 2);
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (out0) void'(q0.pop_front());
                if (in0) q0.push_back(nop ? NOP : pre_data);
                if (out1) void'(q1.pop_front());
                if (in1) q1.push_back(nop ? NOP : pre_data);
            end
            if (q0.size() != 0) last0 = q0[0];
            if (q1.size() != 0) last1 = q1[0];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid0", 32'(pv0), 32'(q0.size() != 0));
            chk("m_data0", 32'(pd0), 32'(last0));
            chk("m_ready0", 32'(rdy0), 32'((q0.size() == 0) || post_ready));
            chk("m_valid1", 32'(pv1), 32'(q1.size() != 0));
            chk("m_data1", 32'(pd1), 32'(last1));
            chk("m_ready1", 32'(rdy1), 32'(q1.size() < 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles while upstream offers data.
        rst = 1'b1; pre_valid = 1'b1; pre_data = 8'hAA;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_valid0", 32'(pv0), 32'd0);
        chk("rst_data0", 32'(pd0), 32'hE5);
        chk("rst_valid1", 32'(pv1), 32'd0);
        chk("rst_data1", 32'(pd1), 32'hE5);
        rst = 1'b0; pre_valid = 1'b0;
        chk("rst_ready1", 32'(rdy1), 32'd1);

        // Streaming 0..15 with downstream always ready.
        post_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            pre_valid = 1'b1; pre_data = 8'(k);
            tick();
            chk("stream_v0", 32'(pv0), 32'd1);
            chk("stream_d0", 32'(pd0), 32'(k));
            chk("stream_v1", 32'(pv1), 32'd1);
            chk("stream_d1", 32'(pd1), 32'(k));
        end
        pre_valid = 1'b0;
        tick();
        chk("stream_idle1", 32'(pv1), 32'd0);

        // Backpressure fills the skid buffer.
        post_ready = 1'b0;
        pre_valid = 1'b1; pre_data = 8'h11;
        tick();
        pre_data = 8'h22;
        tick();
        pre_valid = 1'b0;
        chk("bp_ready1", 32'(rdy1), 32'd0);
        chk("bp_head1", 32'(pd1), 32'h11);
        chk("bp_valid1", 32'(pv1), 32'd1);
        post_ready = 1'b1;
        tick();
        chk("bp_second1", 32'(pd1), 32'h22);
        chk("bp_valid1b", 32'(pv1), 32'd1);
        chk("bp_ready1b", 32'(rdy1), 32'd1);
        tick();
        chk("bp_drained1", 32'(pv1), 32'd0);

        // Nop substitution, then nop without valid.
        pre_valid = 1'b1; nop = 1'b1; pre_data = 8'h5C;
        tick();
        chk("nop_v0", 32'(pv0), 32'd1);
        chk("nop_d0", 32'(pd0), 32'h13);
        chk("nop_v1", 32'(pv1), 32'd1);
        chk("nop_d1", 32'(pd1), 32'h13);
        pre_valid = 1'b0; pre_data = 8'h99;
        tick();
        nop = 1'b0;
        chk("nop_idle0", 32'(pv0), 32'd0);
        chk("nop_idle1", 32'(pv1), 32'd0);

        // Flush while full, with upstream still offering data.
        post_ready = 1'b0;
        pre_valid = 1'b1; pre_data = 8'h31;
        tick();
        pre_data = 8'h32;
        tick();
        pre_data = 8'h33; flush = 1'b1;
        tick();
        flush = 1'b0; pre_valid = 1'b0;
        chk("fl_v0", 32'(pv0), 32'd0);
        chk("fl_v1", 32'(pv1), 32'd0);
        chk("fl_ready1", 32'(rdy1), 32'd1);
        post_ready = 1'b1; pre_valid = 1'b1; pre_data = 8'h77;
        tick();
        pre_valid = 1'b0;
        chk("fl_77_d0", 32'(pd0), 32'h77);
        chk("fl_77_d1", 32'(pd1), 32'h77);
        tick();
        chk("fl_alone0", 32'(pv0), 32'd0);
        chk("fl_alone1", 32'(pv1), 32'd0);

        // Flush from empty discards an accepted beat.
        flush = 1'b1; pre_valid = 1'b1; pre_data = 8'h44;
        tick();
        flush = 1'b0; pre_valid = 1'b0;
        chk("fl_in_v0", 32'(pv0), 32'd0);
        chk("fl_in_v1", 32'(pv1), 32'd0);

`ifdef PIPE_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perf_rst_st0", st0, 32'd0);
        chk("perf_rst_fl1", fl1, 32'd0);
        post_ready = 1'b0; pre_valid = 1'b1; pre_data = 8'h55;
        tick();
        pre_valid = 1'b0;
        repeat (5) tick();
        post_ready = 1'b1;
        tick();
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        chk("perf_st0", st0, 32'd5);
        chk("perf_st1", st1, 32'd5);
        chk("perf_fl0", fl0, 32'd2);
        chk("perf_fl1", fl1, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perf_clr_st1", st1, 32'd0);
        chk("perf_clr_fl0", fl0, 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised valid/ready pipeline stage register for the in-order core. It replaces the hand-written per-boundary stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Payload is one flat vector; the instantiating stage packs and unpacks its fields.
- Adds three things to the plain stage register: an optional 2-entry skid mode with registered upstream ready, a synchronous flush, and bubble (nop) substitution with a parametrised nop payload.

Parameters:
- WIDTH, 64, payload width in bits (≥1).
- NOP_VAL, '0, WIDTH-bit payload captured in place of i_pre_data when i_nop=1.
- RST_VAL, '0, WIDTH-bit reset value of the main and skid payload registers.
- SKID, 0, 0 = single register with combinational ready; 1 = 2-entry skid buffer with registered o_pre_ready.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  drop all held entries; takes effect at the next edge.
- i_nop  in  1  substitute NOP_VAL for the payload on the entry captured this cycle.
- i_pre_valid  in  1  upstream valid.
- o_pre_ready  out  1  ready to upstream.
- i_pre_data  in  WIDTH  upstream payload.
- o_post_valid  out  1  downstream valid.
- i_post_ready  in  1  downstream ready.
- o_post_data  out  WIDTH  downstream payload; always driven from the main register.
- o_perf_stall  out  32  stall counter; present only with PIPE_PERF_CNT_EN.
- o_perf_flush  out  32  flush counter; present only with PIPE_PERF_CNT_EN.

Behaviour:
- Transfer definitions:
  - Input transfer (in_fire) = i_pre_valid & o_pre_ready.
  - Output transfer (out_fire) = o_post_valid & i_post_ready.
- Captured payload:
  - cap = i_nop ? NOP_VAL : i_pre_data.
  - A nop still propagates as a valid entry (bubble carries valid).
- Reset:
  - o_post_valid=0, skid valid=0, o_post_data=RST_VAL, skid data=RST_VAL, perf counters=0.
  - SKID=1: o_pre_ready=1 in the cycle after reset.
  - Reset has priority over flush and over any transfer.
- SKID=0:
  - o_pre_ready = !o_post_valid | i_post_ready (combinational).
  - On in_fire: main ← cap and valid ← 1.
  - Else on out_fire: valid ← 0.
  - Latency is 1 cycle; full throughput.
- SKID=1 state machine:
  - States: EMPTY (main invalid), ONE (main valid), TWO (main + skid valid).
  - o_pre_ready = (state != TWO), driven from a flop with no combinational path from i_post_ready.
  - EMPTY:
    - in_fire → ONE, main ← cap.
  - ONE:
    - in_fire & out_fire → ONE, main ← cap.
    - in_fire & !out_fire → TWO, skid ← cap.
    - !in_fire & out_fire → EMPTY.
  - TWO:
    - No in_fire is possible.
    - out_fire → ONE, main ← skid.
  - Ordering is FIFO: the skid entry is never overtaken.
  - Latency is 1 cycle; sustained throughput is 1/cycle.
- Flush:
  - At the next edge, all valids ← 0 and state → EMPTY.
  - Any in_fire in the flush cycle completes its handshake on the upstream side, but its data is discarded.
  - out_fire in the flush cycle is honoured downstream; the consumer owns its own flush.
  - Payload registers are not cleared on flush.
- Payload registers update only on capture or skid promotion; no X propagation.
- Simultaneous i_nop with !i_pre_valid has no effect.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - o_perf_stall increments every cycle o_post_valid & !i_post_ready.
  - o_perf_flush increments every cycle i_flush=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on i_rst.
- When undefined: both ports and both counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - skid state enum (ST_EMPTY, ST_ONE, ST_TWO).
  - PERF_CNT_W = 32.
- Reuse stl_reg for all flops, with a synchronous active-high variant.
- Sub-module pipe_skid_ctrl (state FSM plus ready/valid generation) is natural. It is instantiated only when SKID=1; the SKID=0 path stays inline.

Test Plan:
- Reset, SKID=1, WIDTH=8:
  - Assert i_rst 2 cycles with i_pre_valid=1, data=8'hAA → o_post_valid=0, o_post_data=RST_VAL.
  - o_pre_ready=1 in the first cycle after reset release.
- Streaming, SKID=0 and SKID=1:
  - 16 back-to-back beats 0..15 with i_post_ready=1 → outputs 0..15 in order, 1-cycle latency, no idle cycles.
- Backpressure, SKID=1:
  - Send 8'h11 then 8'h22 with i_post_ready=0 → state TWO, o_pre_ready=0, o_post_data=8'h11.
  - Raise ready → 8'h11 then 8'h22 out on consecutive cycles, o_pre_ready=1 one cycle after the first out_fire.
- Nop:
  - i_nop=1 with i_pre_valid=1, data=8'h5C, NOP_VAL=8'h13 → o_post_valid=1, o_post_data=8'h13.
  - i_nop with i_pre_valid=0 → no entry created.
- Flush in state TWO with a concurrent in_fire attempt:
  - → next cycle o_post_valid=0, state EMPTY.
  - Subsequent beat 8'h77 emerges alone.
- PIPE_PERF_CNT_EN:
  - Stall 5 cycles, flush 2 cycles → o_perf_stall=5, o_perf_flush=2.
  - i_rst → both counters 0.
